if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 119 +++++++++++
 tb/tb_if_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues one outstanding imem request at a time and
// keeps a one-entry output buffer (pc_out/instruction_out/inst_valid) for IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        inst_valid
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] pc_out_n, instruction_out_n;
  logic        inst_valid_n;
  logic        consume, room;
  logic [31:0] next_addr;

  // imem handshake: imem_req stays high with imem_addr stable until the
  // single-cycle imem_ack, whose imem_rdata is valid in that same cycle.
  assign imem_req  = (state != IDLE);
  assign imem_addr = req_addr;

  assign consume   = inst_valid && !freeze;
  assign room      = !inst_valid || consume;
  assign next_addr = req_addr + STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      fetch_pc        <= RESET_PC;
      req_addr        <= RESET_PC;
      pc_out          <= 32'h0;
      instruction_out <= 32'h0;
      inst_valid      <= 1'b0;
    end else begin
      state           <= state_n;
      fetch_pc        <= fetch_pc_n;
      req_addr        <= req_addr_n;
      pc_out          <= pc_out_n;
      instruction_out <= instruction_out_n;
      inst_valid      <= inst_valid_n;
    end
  end

  always_comb begin
    state_n           = state;
    fetch_pc_n        = fetch_pc;
    req_addr_n        = req_addr;
    pc_out_n          = pc_out;
    instruction_out_n = instruction_out;
    inst_valid_n      = inst_valid;

    if (consume) begin
      inst_valid_n      = 1'b0;
      instruction_out_n = 32'h0;
    end

    if (branch_taken) begin
      fetch_pc_n        = branch_addr;
      inst_valid_n      = 1'b0;
      instruction_out_n = 32'h0;
      case (state)
        IDLE:    state_n = IDLE;
        REQ:     state_n = imem_ack ? IDLE : SQUASH;
        SQUASH:  state_n = imem_ack ? IDLE : SQUASH;
        default: state_n = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (room) begin
            state_n    = REQ;
            req_addr_n = fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (room) begin
              pc_out_n          = next_addr;
              instruction_out_n = imem_rdata;
              inst_valid_n      = 1'b1;
              fetch_pc_n        = next_addr;
              state_n           = REQ;
              req_addr_n        = next_addr;
            end else begin
              // Buffer still held by freeze: drop this word and leave fetch_pc
              // at req_addr so the same address is fetched again once freed.
              state_n = IDLE;
            end
          end
        end
        SQUASH: begin
          if (imem_ack) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: sequential fetch, freeze hold, squashed
// branches, address wrap and asynchronous reset mid-request.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        inst_valid;

  int pass_cnt;
  int total_cnt;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .pc_out         (pc_out),
    .instruction_out(instruction_out),
    .inst_valid     (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic f, input logic b, input logic [31:0] ba,
                        input logic a, input logic [31:0] d);
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
    imem_ack     = a;
    imem_rdata   = d;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1 rst = 1'b1;
    #1;
    check("rst_req",   {31'h0, imem_req},   32'h0);
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_instr", instruction_out,     32'h0);
    check("rst_pc",    pc_out,              32'h0);
    cyc();
    cyc();
    rst = 1'b0;

    // Sequential zero-wait fetch
    cyc();
    check("seq_req0",  {31'h0, imem_req}, 32'h1);
    check("seq_addr0", imem_addr,         32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0000);
    cyc();
    check("seq_pc4",    pc_out,            32'h4);
    check("seq_instr0", instruction_out,   32'hC0DE_0000);
    check("seq_valid0", {31'h0, inst_valid}, 32'h1);
    check("seq_addr4",  imem_addr,         32'h4);
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0004);
    cyc();
    check("seq_pc8",    pc_out,          32'h8);
    check("seq_instr4", instruction_out, 32'hC0DE_0004);
    check("seq_addr8",  imem_addr,       32'h8);

    // Freeze for 3 cycles while holding pc_out=8
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'hC0DE_0008);
    cyc();
    check("frz_req0",   {31'h0, imem_req}, 32'h0);
    check("frz_pc_a",   pc_out,            32'h8);
    check("frz_instr_a", instruction_out,  32'hC0DE_0004);
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
    cyc();
    check("frz_idle_ack_pc",    pc_out,          32'h8);
    check("frz_idle_ack_instr", instruction_out, 32'hC0DE_0004);
    check("frz_req1",           {31'h0, imem_req}, 32'h0);
    set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc();
    check("frz_valid_c", {31'h0, inst_valid}, 32'h1);
    check("frz_req2",    {31'h0, imem_req},   32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc();
    check("resume_req",   {31'h0, imem_req},   32'h1);
    check("resume_addr",  imem_addr,           32'h8);
    check("resume_valid", {31'h0, inst_valid}, 32'h0);
    check("resume_instr", instruction_out,     32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0008);
    cyc();
    check("resume_pc12",  pc_out,          32'hC);
    check("resume_instr8", instruction_out, 32'hC0DE_0008);

    // Delayed ack with branch in first wait cycle
    set_in(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    cyc();
    check("sq_req",   {31'h0, imem_req},   32'h1);
    check("sq_addr",  imem_addr,           32'hC);
    check("sq_valid", {31'h0, inst_valid}, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc();
    check("sq_wait_addr",  imem_addr,           32'hC);
    check("sq_wait_valid", {31'h0, inst_valid}, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    cyc();
    check("sq_drop_req",   {31'h0, imem_req},   32'h0);
    check("sq_drop_valid", {31'h0, inst_valid}, 32'h0);
    check("sq_drop_instr", instruction_out,     32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc();
    check("br100_req",  {31'h0, imem_req}, 32'h1);
    check("br100_addr", imem_addr,         32'h100);
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0100);
    cyc();
    check("br100_pc",    pc_out,          32'h104);
    check("br100_instr", instruction_out, 32'hC0DE_0100);

    // Branch and ack in the same REQ cycle
    set_in(1'b0, 1'b1, 32'h40, 1'b1, 32'hBAD0_0104);
    cyc();
    check("brack_req",   {31'h0, imem_req},   32'h0);
    check("brack_valid", {31'h0, inst_valid}, 32'h0);
    check("brack_instr", instruction_out,     32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc();
    check("br40_addr", imem_addr, 32'h40);
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_0040);
    cyc();
    check("br40_pc", pc_out, 32'h44);

    // Address wrap at the top of the space
    set_in(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hBAD0_0044);
    cyc();
    check("wrap_br_valid", {31'h0, inst_valid}, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc();
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hC0DE_FFFC);
    cyc();
    check("wrap_pc",    pc_out,          32'h0);
    check("wrap_instr", instruction_out, 32'hC0DE_FFFC);
    check("wrap_addr",  imem_addr,       32'h0);

    // Asynchronous reset while request to 0 is outstanding
    set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #3 rst = 1'b1;
    #1;
    check("arst_req",   {31'h0, imem_req},   32'h0);
    check("arst_valid", {31'h0, inst_valid}, 32'h0);
    check("arst_instr", instruction_out,     32'h0);
    check("arst_pc",    pc_out,              32'h0);
    cyc();
    rst = 1'b0;
    cyc();
    check("post_rst_req",  {31'h0, imem_req}, 32'h1);
    check("post_rst_addr", imem_addr,         32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
